scoreboard_register_file: RTL and testbench
===========================================

SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001 Parameter DATA_W, default 32, sets the register data width in bits.
REQ-002 Parameter ADDR_W, default 5, sets the address width; depth is 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 1, makes register 0 read as constant zero when set to 1.
REQ-004 The block SHALL use one clock, CLK, and reset is synchronous and active-high on RST.
REQ-005 CLK  in  1  clock; all state updates on its rising edge.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 RA_ADDR  in  ADDR_W  read port A address.
REQ-008 RA_DATA  out  DATA_W  read port A data, combinational.
REQ-009 RA_BUSY  out  1  read port A register pending a write.
REQ-010 RB_ADDR, RB_DATA, RB_BUSY: same as port A, with the same directions and widths, for port B.
REQ-011 WE  in  1  write enable.
REQ-012 W_ADDR  in  ADDR_W  write address.
REQ-013 W_DATA  in  DATA_W  write data.
REQ-014 RSV  in  1  reserve request, which marks the destination busy.
REQ-015 RSV_ADDR  in  ADDR_W  register to reserve.
REQ-016 RSV_OK  out  1  reservation accepted this cycle, combinational.
REQ-017 BUSY_CNT  out  ADDR_W+1  registered count of busy registers.

Function
REQ-018 The data array SHALL be edge-triggered: if WE=1 at a rising CLK edge, reg[W_ADDR] <= W_DATA; no level-sensitive latching.
REQ-019 With ZERO_REG=1:
 - writes to address 0 SHALL be discarded;
 - reads of address 0 SHALL return 0 with BUSY=0;
 - RSV to address 0 SHALL give RSV_OK=1 without setting any busy bit.
REQ-020 Read ports SHALL bypass: if WE=1 and W_ADDR equals the read address (not a discarded zero-register write), RA_DATA/RB_DATA SHALL equal W_DATA in that same cycle.
REQ-021 The busy bit per register SHALL be set at the edge when RSV=1 and RSV_OK=1, and cleared at the edge when WE=1 for that address.
REQ-022 RA_BUSY/RB_BUSY SHALL equal busy[addr], forced to 0 when a same-cycle write to that address is present.
REQ-023 RSV_OK SHALL be 1 when RSV=1 and either:
 - busy[RSV_ADDR]=0, or
 - WE=1 with W_ADDR=RSV_ADDR.
 Otherwise RSV_OK SHALL be 0 and no state changes for the reservation.
REQ-024 When a write and an accepted reservation hit the same address in the same cycle:
 - the data SHALL be written;
 - the busy bit SHALL end at 1 (reservation wins).
REQ-025 BUSY_CNT SHALL change at each edge by +1 for an accepted reservation that sets a previously clear bit.
REQ-026 BUSY_CNT SHALL change at each edge by -1 for a write that clears a set bit which is not re-reserved in the same cycle.
REQ-027 When both REQ-025 and REQ-026 apply in one cycle, BUSY_CNT SHALL change by their sum (net 0).
REQ-028 BUSY_CNT SHALL equal the popcount of the busy bits at all times; the maximum is 2**ADDR_W - ZERO_REG, and it SHALL never wrap.
REQ-029 A write to a non-busy register SHALL be legal: it updates data and leaves the busy bit and BUSY_CNT unchanged.
REQ-030 Out-of-range conditions do not exist: all ADDR_W-bit addresses are valid.

Reset
REQ-031 On a rising CLK edge with RST=1:
 - all registers SHALL become 0;
 - all busy bits SHALL clear;
 - BUSY_CNT SHALL become 0;
 - RST SHALL have priority over WE and RSV in that cycle.
REQ-032 Reset SHALL be legal mid-operation; outstanding reservations are discarded and no write is lost except the one coincident with RST.
REQ-033 After reset, RA_DATA/RB_DATA SHALL read 0 for every address, subject to bypass per REQ-020.

Verification
REQ-034 Reset, then read all 32 addresses on both ports -> every DATA=0, BUSY=0, BUSY_CNT=0.
REQ-035 Write 0xDEADBEEF to r5 with RA_ADDR=5 in the same cycle -> RA_DATA=0xDEADBEEF before the edge; after the edge RB_ADDR=5 also returns 0xDEADBEEF.
REQ-036 Write 0x12345678 to r0 -> r0 reads 0; RSV r0 -> RSV_OK=1, BUSY_CNT stays 0.
REQ-037 Reservation sequence:
 - RSV r7 -> RSV_OK=1, BUSY_CNT=1, RA_BUSY(7)=1;
 - RSV r7 again -> RSV_OK=0, BUSY_CNT=1;
 - WE r7=0xA5 together with RSV r7 -> RSV_OK=1, r7=0xA5, busy stays 1, BUSY_CNT=1.
REQ-038 Reserve r1..r31 on consecutive cycles -> BUSY_CNT=31; then assert RST with WE r3=0x55 -> all zero, BUSY_CNT=0, r3=0.
REQ-039 Reserve r9, then write r9=0x1 in the same cycle as reserving r10 -> BUSY_CNT stays 1, r9 not busy, r10 busy.

Source files
------------

// File: rtl/scoreboard_register_file.sv
// scoreboard_register_file
//   Register file with two combinational read ports, one write port and a
//   per-register busy scoreboard used to track in-flight producers.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   RA_ADDR/RB_ADDR     read addresses
//   RA_DATA/RB_DATA     read data, combinational, with write-port bypass
//   RA_BUSY/RB_BUSY     busy bit of the addressed register
//   WE, W_ADDR, W_DATA  write port; a write also retires the busy bit
//   RSV, RSV_ADDR       reserve request (marks destination busy)
//   RSV_OK              reservation accepted this cycle
//   BUSY_CNT            registered popcount of the busy bits
module scoreboard_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] RA_ADDR,
  output logic [DATA_W-1:0] RA_DATA,
  output logic              RA_BUSY,
  input  logic [ADDR_W-1:0] RB_ADDR,
  output logic [DATA_W-1:0] RB_DATA,
  output logic              RB_BUSY,
  input  logic              WE,
  input  logic [ADDR_W-1:0] W_ADDR,
  input  logic [DATA_W-1:0] W_DATA,
  input  logic              RSV,
  input  logic [ADDR_W-1:0] RSV_ADDR,
  output logic              RSV_OK,
  output logic [ADDR_W:0]   BUSY_CNT
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

  logic w_eff;     // write that actually lands (not a discarded r0 write)
  logic rsv_zero;  // reservation of the hardwired zero register
  logic rsv_set;   // reservation that sets a busy bit
  logic cnt_inc, cnt_dec;

  assign w_eff    = WE && !((ZERO_REG != 0) && (W_ADDR == '0));
  assign rsv_zero = (ZERO_REG != 0) && (RSV_ADDR == '0);

  // A busy register can be re-reserved in the same cycle its producer writes it.
  assign RSV_OK  = RSV && (rsv_zero || !busy_q[RSV_ADDR] || (WE && (W_ADDR == RSV_ADDR)));
  assign rsv_set = RSV_OK && !rsv_zero;

  // Read ports: zero register first, then bypass, then array.
  always_comb begin
    RA_DATA = mem_q[RA_ADDR];
    RA_BUSY = busy_q[RA_ADDR];
    if ((ZERO_REG != 0) && (RA_ADDR == '0)) begin
      RA_DATA = '0;
      RA_BUSY = 1'b0;
    end else if (w_eff && (W_ADDR == RA_ADDR)) begin
      RA_DATA = W_DATA;
      RA_BUSY = 1'b0;
    end
  end

  always_comb begin
    RB_DATA = mem_q[RB_ADDR];
    RB_BUSY = busy_q[RB_ADDR];
    if ((ZERO_REG != 0) && (RB_ADDR == '0)) begin
      RB_DATA = '0;
      RB_BUSY = 1'b0;
    end else if (w_eff && (W_ADDR == RB_ADDR)) begin
      RB_DATA = W_DATA;
      RB_BUSY = 1'b0;
    end
  end

  // Next state: write clears, reservation sets afterwards so it wins a tie.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (w_eff) begin
      mem_d[W_ADDR]  = W_DATA;
      busy_d[W_ADDR] = 1'b0;
    end
    if (rsv_set) busy_d[RSV_ADDR] = 1'b1;
  end

  // Counter tracks the popcount incrementally; a write+reserve on an already
  // busy register leaves both terms zero, so the count cannot drift or wrap.
  assign cnt_inc = rsv_set && !busy_q[RSV_ADDR];
  assign cnt_dec = w_eff && busy_q[W_ADDR] && !(rsv_set && (RSV_ADDR == W_ADDR));

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    case ({cnt_inc, cnt_dec})
      2'b10:   busy_cnt_d = busy_cnt_q + 1'b1;
      2'b01:   busy_cnt_d = busy_cnt_q - 1'b1;
      default: busy_cnt_d = busy_cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign BUSY_CNT = busy_cnt_q;

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed bench for scoreboard_register_file. Stimulus drives inputs after
// each rising edge and queues the expected outputs; a monitor on the falling
// edge drains the queue and compares against the live outputs.
module tb_scoreboard_register_file;

  localparam int DW = 32;
  localparam int AW = 5;

  localparam int S_RA_DATA = 0, S_RA_BUSY = 1, S_RB_DATA = 2,
                 S_RB_BUSY = 3, S_RSV_OK = 4, S_CNT = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] RA_ADDR, RB_ADDR, W_ADDR, RSV_ADDR;
  logic [DW-1:0] RA_DATA, RB_DATA, W_DATA;
  logic          RA_BUSY, RB_BUSY, WE, RSV, RSV_OK;
  logic [AW:0]   BUSY_CNT;
  logic          done = 1'b0;

  scoreboard_register_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .CLK(CLK), .RST(RST),
    .RA_ADDR(RA_ADDR), .RA_DATA(RA_DATA), .RA_BUSY(RA_BUSY),
    .RB_ADDR(RB_ADDR), .RB_DATA(RB_DATA), .RB_BUSY(RB_BUSY),
    .WE(WE), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
    .RSV(RSV), .RSV_ADDR(RSV_ADDR), .RSV_OK(RSV_OK),
    .BUSY_CNT(BUSY_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          sig;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic push_exp(input int sig, input logic [63:0] v, input string nm);
    exp_t e;
    e.sig = sig; e.exp = v; e.name = nm;
    q.push_back(e);
  endtask

  function automatic logic [63:0] actual(input int sig);
    case (sig)
      S_RA_DATA: return 64'(RA_DATA);
      S_RA_BUSY: return 64'(RA_BUSY);
      S_RB_DATA: return 64'(RB_DATA);
      S_RB_BUSY: return 64'(RB_BUSY);
      S_RSV_OK:  return 64'(RSV_OK);
      default:   return 64'(BUSY_CNT);
    endcase
  endfunction

  // Monitor: every falling edge, check everything queued for this cycle.
  always @(negedge CLK) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [63:0] a;
      e = q.pop_front();
      a = actual(e.sig);
      n_chk++;
      if (a === e.exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, a, e.exp);
    end
  end

  initial begin
    repeat (5000) @(posedge CLK);
    if (!done) begin
      $display("FAIL timeout: test did not complete within 5000 cycles");
      $finish;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    RST = 1'b0; WE = 1'b0; RSV = 1'b0;
    W_ADDR = '0; W_DATA = '0; RSV_ADDR = '0;
  endtask

  initial begin
    RA_ADDR = '0; RB_ADDR = '0;
    idle();
    RST = 1'b1;
    tick(); tick();
    idle();

    n_chk++;
    if (BUSY_CNT === '0 && RA_BUSY === 1'b0 && RB_BUSY === 1'b0 &&
        RA_DATA === '0 && RB_DATA === '0)
      n_pass++;
    else
      $display("FAIL reset_state: cnt=0x%0h ra_busy=%b rb_busy=%b ra=0x%0h rb=0x%0h",
               BUSY_CNT, RA_BUSY, RB_BUSY, RA_DATA, RB_DATA);

    // Post-reset sweep of both ports
    for (int a = 0; a < 32; a++) begin
      RA_ADDR = AW'(a); RB_ADDR = AW'(31 - a);
      push_exp(S_RA_DATA, 0, "rst_ra_data");
      push_exp(S_RA_BUSY, 0, "rst_ra_busy");
      push_exp(S_RB_DATA, 0, "rst_rb_data");
      push_exp(S_RB_BUSY, 0, "rst_rb_busy");
      push_exp(S_CNT,     0, "rst_cnt");
      tick();
    end

    // Same-cycle bypass then array read of r5
    WE = 1; W_ADDR = 5; W_DATA = 32'hDEADBEEF; RA_ADDR = 5; RB_ADDR = 6;
    push_exp(S_RA_DATA, 32'hDEADBEEF, "bypass_ra_r5");
    push_exp(S_RB_DATA, 0, "bypass_rb_other");
    tick();
    idle(); RA_ADDR = 4; RB_ADDR = 5;
    push_exp(S_RB_DATA, 32'hDEADBEEF, "read_rb_r5");
    push_exp(S_RA_DATA, 0, "read_ra_r4");
    push_exp(S_CNT, 0, "write_nonbusy_cnt");
    tick();

    // Zero register: writes discarded, reservations accepted but not tracked
    WE = 1; W_ADDR = 0; W_DATA = 32'h12345678; RA_ADDR = 0; RB_ADDR = 0;
    push_exp(S_RA_DATA, 0, "r0_write_bypass_ra");
    push_exp(S_RB_DATA, 0, "r0_write_bypass_rb");
    tick();
    idle(); RSV = 1; RSV_ADDR = 0; RA_ADDR = 0;
    push_exp(S_RA_DATA, 0, "r0_read_after_write");
    push_exp(S_RSV_OK, 1, "r0_rsv_ok");
    tick();
    idle();
    push_exp(S_CNT, 0, "r0_rsv_cnt");
    push_exp(S_RA_BUSY, 0, "r0_busy");
    tick();

    // Reservation sequence on r7
    RSV = 1; RSV_ADDR = 7; RA_ADDR = 7;
    push_exp(S_RSV_OK, 1, "r7_rsv1_ok");
    push_exp(S_CNT, 0, "r7_rsv1_cnt_before");
    tick();
    push_exp(S_RSV_OK, 0, "r7_rsv2_rejected");
    push_exp(S_CNT, 1, "r7_rsv2_cnt");
    push_exp(S_RA_BUSY, 1, "r7_busy");
    tick();
    WE = 1; W_ADDR = 7; W_DATA = 32'hA5; RB_ADDR = 7;
    push_exp(S_RSV_OK, 1, "r7_wr_rsv_ok");
    push_exp(S_RA_DATA, 32'hA5, "r7_wr_bypass");
    push_exp(S_RB_BUSY, 0, "r7_wr_busy_forced0");
    push_exp(S_CNT, 1, "r7_wr_cnt_before");
    tick();
    idle();
    push_exp(S_RA_DATA, 32'hA5, "r7_data_after");
    push_exp(S_RA_BUSY, 1, "r7_busy_after_tie");
    push_exp(S_CNT, 1, "r7_cnt_after_tie");
    tick();
    WE = 1; W_ADDR = 7; W_DATA = 32'h77;
    tick();
    idle();
    push_exp(S_CNT, 0, "r7_retire_cnt");
    push_exp(S_RA_BUSY, 0, "r7_retire_busy");
    push_exp(S_RA_DATA, 32'h77, "r7_retire_data");
    tick();

    // Retire r9 while reserving r10
    RSV = 1; RSV_ADDR = 9;
    push_exp(S_RSV_OK, 1, "r9_rsv_ok");
    tick();
    idle(); WE = 1; W_ADDR = 9; W_DATA = 32'h1; RSV = 1; RSV_ADDR = 10;
    push_exp(S_RSV_OK, 1, "r10_rsv_ok");
    push_exp(S_CNT, 1, "r9r10_cnt_before");
    tick();
    idle(); RA_ADDR = 9; RB_ADDR = 10;
    push_exp(S_CNT, 1, "r9r10_cnt_after");
    push_exp(S_RA_BUSY, 0, "r9_not_busy");
    push_exp(S_RB_BUSY, 1, "r10_busy");
    push_exp(S_RA_DATA, 1, "r9_data");
    tick();
    WE = 1; W_ADDR = 10; W_DATA = 32'h10;
    tick();
    idle();
    push_exp(S_CNT, 0, "r10_retire_cnt");
    tick();

    // Fill the scoreboard, then reset over a coincident write
    for (int a = 1; a < 32; a++) begin
      RSV = 1; RSV_ADDR = AW'(a);
      push_exp(S_RSV_OK, 1, "fill_rsv_ok");
      push_exp(S_CNT, 64'(a - 1), "fill_cnt");
      tick();
    end
    idle(); RSV = 1; RSV_ADDR = 0; RA_ADDR = 3; RB_ADDR = 5;
    push_exp(S_CNT, 31, "full_cnt");
    push_exp(S_RSV_OK, 1, "full_r0_rsv_ok");
    push_exp(S_RA_BUSY, 1, "full_r3_busy");
    push_exp(S_RB_DATA, 32'hDEADBEEF, "full_r5_data");
    tick();
    idle(); RSV = 1; RSV_ADDR = 12;
    push_exp(S_RSV_OK, 0, "full_r12_rejected");
    tick();
    idle(); RST = 1; WE = 1; W_ADDR = 3; W_DATA = 32'h55; RSV = 1; RSV_ADDR = 3;
    tick();
    idle(); RA_ADDR = 3; RB_ADDR = 5;
    push_exp(S_RA_DATA, 0, "post_rst_r3");
    push_exp(S_RA_BUSY, 0, "post_rst_r3_busy");
    push_exp(S_RB_DATA, 0, "post_rst_r5");
    push_exp(S_RB_BUSY, 0, "post_rst_r5_busy");
    push_exp(S_CNT, 0, "post_rst_cnt");
    tick();
    RA_ADDR = 7; RB_ADDR = 9;
    push_exp(S_RA_DATA, 0, "post_rst_r7");
    push_exp(S_RB_DATA, 0, "post_rst_r9");
    tick();

    @(negedge CLK);
    #1;
    done = 1'b1;
    if (q.size() != 0) $display("FAIL queue: %0d expectations unchecked", q.size());
    if (n_pass != n_chk) $display("FAIL summary: %0d of %0d checks failed", n_chk - n_pass, n_chk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
